// File: rtl/jpeg_tables_pkg.sv
// JPEG baseline tables shared by the zigzag/quantiser stages: zigzag scan order,
// quality-50 luma/chroma reciprocals (round(65536/Q)), component codes and FSM states.
package jpeg_tables_pkg;

   localparam logic [1:0] COMP_Y  = 2'd0;
   localparam logic [1:0] COMP_CB = 2'd1;
   localparam logic [1:0] COMP_CR = 2'd2;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StStream = 2'd1,
      StFlush  = 2'd2
   } state_e;

   // round(65536/q) for q >= 1; q is never odd-divides-2^17 except 1, so no ties arise
   function automatic logic [16:0] rcp(input int unsigned q);
      return 17'((32'd65536 + q / 2) / q);
   endfunction

   // Zigzag index -> natural raster index
   localparam logic [5:0] ZZ_ORDER [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   // Indexed by natural raster position
   localparam logic [16:0] LUMA_RECIP [64] = '{
      rcp(16), rcp(11), rcp(10), rcp(16), rcp(24),  rcp(40),  rcp(51),  rcp(61),
      rcp(12), rcp(12), rcp(14), rcp(19), rcp(26),  rcp(58),  rcp(60),  rcp(55),
      rcp(14), rcp(13), rcp(16), rcp(24), rcp(40),  rcp(57),  rcp(69),  rcp(56),
      rcp(14), rcp(17), rcp(22), rcp(29), rcp(51),  rcp(87),  rcp(80),  rcp(62),
      rcp(18), rcp(22), rcp(37), rcp(56), rcp(68),  rcp(109), rcp(103), rcp(77),
      rcp(24), rcp(35), rcp(55), rcp(64), rcp(81),  rcp(104), rcp(113), rcp(92),
      rcp(49), rcp(64), rcp(78), rcp(87), rcp(103), rcp(121), rcp(120), rcp(101),
      rcp(72), rcp(92), rcp(95), rcp(98), rcp(112), rcp(100), rcp(103), rcp(99)
   };

   localparam logic [16:0] CHROMA_RECIP [64] = '{
      rcp(17), rcp(18), rcp(24), rcp(47), rcp(99), rcp(99), rcp(99), rcp(99),
      rcp(18), rcp(21), rcp(26), rcp(66), rcp(99), rcp(99), rcp(99), rcp(99),
      rcp(24), rcp(26), rcp(56), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99),
      rcp(47), rcp(66), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99),
      rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99),
      rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99),
      rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99),
      rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99), rcp(99)
   };

endpackage

// File: rtl/quant_round_sat.sv
// Combinational signed coefficient x unsigned reciprocal, rounded half away from zero
// and saturated to a symmetric signed range.
module quant_round_sat #(
   parameter int unsigned COEF_W     = 16,
   parameter int unsigned RECIP_W    = 17,
   parameter int unsigned RECIP_FRAC = 16,
   parameter int unsigned QUANT_W    = 12
) (
   input  logic [COEF_W-1:0]  coef_i,
   input  logic [RECIP_W-1:0] recip_i,
   output logic [QUANT_W-1:0] quant_o
);

   localparam int unsigned PROD_W = COEF_W + RECIP_W;
   localparam int unsigned MAG_W  = PROD_W - RECIP_FRAC;
   localparam logic [MAG_W-1:0] MAX_MAG = MAG_W'(2 ** (QUANT_W - 1) - 1);

   logic                neg;
   logic [COEF_W-1:0]   abs_c;
   logic [PROD_W-1:0]   prod;
   logic [PROD_W-1:0]   rounded;
   logic [MAG_W-1:0]    mag;
   logic [QUANT_W-1:0]  sat;

   always_comb begin
      neg     = coef_i[COEF_W-1];
      // Unsigned magnitude: the most negative input maps to 2^(COEF_W-1) without overflow
      abs_c   = neg ? (~coef_i + 1'b1) : coef_i;
      prod    = PROD_W'(abs_c) * PROD_W'(recip_i);
      rounded = prod + (PROD_W'(1) << (RECIP_FRAC - 1));
      mag     = rounded[PROD_W-1:RECIP_FRAC];
      sat     = (mag > MAX_MAG) ? QUANT_W'(MAX_MAG) : mag[QUANT_W-1:0];
      quant_o = neg ? (~sat + 1'b1) : sat;
   end

endmodule

// File: rtl/dct_zigzag_quant.sv
// Takes one 8x8 block of DCT coefficients in parallel and streams the quantised
// coefficients one per beat in zigzag order, with a last flag on index 63.
module dct_zigzag_quant
   import jpeg_tables_pkg::*;
#(
   parameter int unsigned COEF_W      = 16,
   parameter int unsigned PIXEL_COUNT = 64,
   parameter int unsigned RECIP_W     = 17,
   parameter int unsigned RECIP_FRAC  = 16,
   parameter int unsigned QUANT_W     = 12
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [PIXEL_COUNT*COEF_W-1:0] in_data,
   input  logic [1:0]                    in_component,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [QUANT_W-1:0]            out_coef,
   output logic [5:0]                    out_index,
   output logic                          out_last,
   output logic [1:0]                    out_component
);

   localparam int unsigned BLOCK_W = PIXEL_COUNT * COEF_W;

   state_e               state_q, state_d;
   logic [BLOCK_W-1:0]   block_q, block_d;
   logic [1:0]           comp_q, comp_d;
   logic [5:0]           k_q, k_d;
   logic                 out_valid_q, out_valid_d;
   logic [QUANT_W-1:0]   out_coef_q, out_coef_d;
   logic [5:0]           out_index_q, out_index_d;
   logic                 out_last_q, out_last_d;
   logic [1:0]           out_component_q, out_component_d;

   logic [5:0]           zz;
   logic [COEF_W-1:0]    coef_sel;
   logic [RECIP_W-1:0]   recip;
   logic                 is_chroma;
   logic                 load;
   logic [QUANT_W-1:0]   quant;

   always_comb begin
      zz        = ZZ_ORDER[k_q];
      coef_sel  = block_q[32'(zz) * COEF_W +: COEF_W];
      is_chroma = (comp_q == COMP_CB) || (comp_q == COMP_CR);
      recip     = RECIP_W'(is_chroma ? CHROMA_RECIP[zz] : LUMA_RECIP[zz]);
      load      = (state_q == StStream) && (!out_valid_q || out_ready);
   end

   quant_round_sat #(
      .COEF_W    (COEF_W),
      .RECIP_W   (RECIP_W),
      .RECIP_FRAC(RECIP_FRAC),
      .QUANT_W   (QUANT_W)
   ) u_quant (
      .coef_i (coef_sel),
      .recip_i(recip),
      .quant_o(quant)
   );

   always_comb begin
      state_d         = state_q;
      block_d         = block_q;
      comp_d          = comp_q;
      k_d             = k_q;
      out_valid_d     = out_valid_q;
      out_coef_d      = out_coef_q;
      out_index_d     = out_index_q;
      out_last_d      = out_last_q;
      out_component_d = out_component_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               block_d = in_data;
               comp_d  = in_component;
               k_d     = '0;
               state_d = StStream;
            end
         end
         StStream: begin
            if (load) begin
               out_valid_d     = 1'b1;
               out_coef_d      = quant;
               out_index_d     = k_q;
               out_last_d      = (k_q == 6'd63);
               out_component_d = comp_q;
               k_d             = k_q + 6'd1;
               if (k_q == 6'd63) state_d = StFlush;
            end
         end
         StFlush: begin
            // Register holds only the final beat here; its acceptance ends the block
            if (out_valid_q && out_ready && out_last_q) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         comp_q          <= '0;
         k_q             <= '0;
         out_valid_q     <= 1'b0;
         out_coef_q      <= '0;
         out_index_q     <= '0;
         out_last_q      <= 1'b0;
         out_component_q <= '0;
      end else begin
         state_q         <= state_d;
         comp_q          <= comp_d;
         k_q             <= k_d;
         out_valid_q     <= out_valid_d;
         out_coef_q      <= out_coef_d;
         out_index_q     <= out_index_d;
         out_last_q      <= out_last_d;
         out_component_q <= out_component_d;
      end
   end

   // Block payload needs no reset: it is always written before being read
   always_ff @(posedge clk) begin
      block_q <= block_d;
   end

   assign in_ready      = (state_q == StIdle);
   assign out_valid     = out_valid_q;
   assign out_coef      = out_coef_q;
   assign out_index     = out_index_q;
   assign out_last      = out_last_q;
   assign out_component = out_component_q;

endmodule

// File: tb/tb_dct_zigzag_quant.sv
// Bench for dct_zigzag_quant: directed and random blocks checked against a
// zigzag-walk / arithmetic quantisation model, with random backpressure and mid-stream reset.
module tb_dct_zigzag_quant;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [1023:0]  in_data;
   logic [1:0]     in_component;
   logic           out_valid;
   logic           out_ready;
   logic [11:0]    out_coef;
   logic [5:0]     out_index;
   logic           out_last;
   logic [1:0]     out_component;

   int n_cmp  = 0;
   int n_fail = 0;

   int blk [64];
   int zz [64];
   int exp_coef [64];
   int rx_coef [64];
   int exp_comp;

   int lq [64] = '{
      16, 11, 10, 16,  24,  40,  51,  61,
      12, 12, 14, 19,  26,  58,  60,  55,
      14, 13, 16, 24,  40,  57,  69,  56,
      14, 17, 22, 29,  51,  87,  80,  62,
      18, 22, 37, 56,  68, 109, 103,  77,
      24, 35, 55, 64,  81, 104, 113,  92,
      49, 64, 78, 87, 103, 121, 120, 101,
      72, 92, 95, 98, 112, 100, 103,  99
   };
   int cq [64];

   always #5 clk = ~clk;

   dct_zigzag_quant #(
      .COEF_W     (16),
      .PIXEL_COUNT(64),
      .RECIP_W    (17),
      .RECIP_FRAC (16),
      .QUANT_W    (12)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_component (in_component),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_coef     (out_coef),
      .out_index    (out_index),
      .out_last     (out_last),
      .out_component(out_component)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic int qmodel(input int c, input int comp, input int p);
      int     q;
      longint recip, a, mag;
      q     = (comp == 1 || comp == 2) ? cq[p] : lq[p];
      recip = (65536 + q / 2) / q;
      a     = (c < 0) ? -c : c;
      mag   = (a * recip + 32768) / 65536;
      if (mag > 2047) mag = 2047;
      return (c < 0) ? -int'(mag) : int'(mag);
   endfunction

   task automatic collect(input int stop, input int pct, input bit noise);
      int          n = 0;
      int          cyc = 0;
      bit          stall = 0;
      bit          r;
      logic [11:0] pc;
      logic [5:0]  pi;
      logic        pl;
      logic [1:0]  pcomp;
      while (n < stop && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         in_valid = noise;
         if (noise) in_data = ~in_data;
         if (stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_coef", $signed(out_coef), $signed(pc));
            chk("stall_index", out_index, pi);
            chk("stall_last", out_last, pl);
            chk("stall_comp", out_component, pcomp);
         end
         chk("in_ready_busy", in_ready, 0);
         r = ($urandom_range(99) < pct);
         out_ready = r;
         if (out_valid) begin
            if (r) begin
               chk("beat_index", out_index, n);
               chk("beat_coef", $signed(out_coef), exp_coef[n]);
               chk("beat_last", out_last, (n == 63));
               chk("beat_comp", out_component, exp_comp);
               rx_coef[n] = int'($signed(out_coef));
               n++;
            end
            stall = !r;
            pc = out_coef; pi = out_index; pl = out_last; pcomp = out_component;
         end else begin
            stall = 0;
         end
      end
      in_valid = 1'b0;
      chk("beat_count", n, stop);
   endtask

   task automatic run_block(input int comp, input int stop, input int pct, input bit noise);
      exp_comp = comp;
      for (int k = 0; k < 64; k++) begin
         exp_coef[k] = qmodel(blk[zz[k]], comp, zz[k]);
         rx_coef[k]  = 0;
      end
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      for (int p = 0; p < 64; p++) in_data[p*16 +: 16] = 16'(blk[p]);
      in_component = 2'(comp);
      in_valid     = 1'b1;
      collect(stop, pct, noise);
      if (stop == 64) begin
         @(negedge clk);
         chk("in_ready_after", in_ready, 1);
         chk("out_valid_after", out_valid, 0);
      end
   endtask

   task automatic clear_blk();
      for (int p = 0; p < 64; p++) blk[p] = 0;
   endtask

   task automatic rand_blk();
      for (int p = 0; p < 64; p++) begin
         if ($urandom_range(3) == 0) blk[p] = int'($signed(16'($urandom)));
         else blk[p] = int'($urandom_range(400)) - 200;
      end
   endtask

   initial begin
      int k, r, c, s;
      // Chroma table: top-left triangle from Annex K, 99 elsewhere
      for (int p = 0; p < 64; p++) cq[p] = 99;
      cq[0] = 17;  cq[1] = 18;  cq[2] = 24;  cq[3] = 47;
      cq[8] = 18;  cq[9] = 21;  cq[10] = 26; cq[11] = 66;
      cq[16] = 24; cq[17] = 26; cq[18] = 56;
      cq[24] = 47; cq[25] = 66;
      // Zigzag as an anti-diagonal walk, alternating direction
      k = 0;
      for (s = 0; s < 15; s++) begin
         if (s % 2 == 0) begin
            for (r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
               c = s - r; zz[k] = r * 8 + c; k++;
            end
         end else begin
            for (r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
               c = s - r; zz[k] = r * 8 + c; k++;
            end
         end
      end

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_component = 2'd0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_coef", out_coef, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_comp", out_component, 0);
      rst = 1'b0;

      clear_blk(); blk[0] = 1024;
      run_block(0, 64, 100, 0);
      chk("dc_luma", rx_coef[0], 64);

      clear_blk(); blk[8] = 120;
      run_block(0, 64, 100, 0);
      chk("zz_place", rx_coef[2], 10);

      clear_blk(); blk[0] = -24;
      run_block(0, 64, 100, 0);
      chk("round_neg", rx_coef[0], -2);

      blk[0] = -32768;
      run_block(0, 64, 100, 0);
      chk("sat_neg", rx_coef[0], -2047);

      blk[0] = 32767;
      run_block(0, 64, 100, 0);
      chk("sat_pos", rx_coef[0], 2047);

      blk[0] = 170;
      run_block(2, 64, 100, 0);
      chk("chroma_cr", rx_coef[0], 10);
      run_block(3, 64, 100, 0);
      chk("comp3_luma", rx_coef[0], 11);

      for (int b = 0; b < 4; b++) begin
         rand_blk();
         run_block(int'($urandom_range(3)), 64, 50, 1);
      end

      rand_blk();
      run_block(1, 21, 50, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_index", out_index, 0);

      rand_blk();
      run_block(0, 64, 70, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
